// File: rtl/example_serial_rx.sv
// rtl/example_serial_rx.sv - framed serial receiver with single-entry valid/ready output buffer
// Optional even-parity bit enabled by defining EXAMPLE_SERIAL_RX_PARITY_EN.
module example_serial_rx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             framing_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_MID  = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bitn_q, bitn_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             framing_err_q, framing_err_d;
  logic             overrun_q, overrun_d;
  logic             line;
  logic             cyc_end;
  logic             good_stop;
`ifdef EXAMPLE_SERIAL_RX_PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  assign line    = sync2_q;
  assign cyc_end = (cyc_q == CYC_LAST);

  always_comb begin
    state_d       = state_q;
    sync1_d       = data_in;
    sync2_d       = sync1_q;
    cyc_d         = cyc_end ? '0 : cyc_q + 1'b1;
    bitn_d        = bitn_q;
    word_d        = word_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    framing_err_d = 1'b0;
    overrun_d     = 1'b0;
    good_stop     = 1'b0;
`ifdef EXAMPLE_SERIAL_RX_PARITY_EN
    par_d         = par_q;
    parity_err_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (!line) state_d = START;
      end
      START: begin
        // Re-check half a bit in; from here every later sample lands mid-bit.
        if (cyc_q == CYC_MID) begin
          cyc_d = '0;
          if (!line) begin
            state_d = DATA;
            bitn_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cyc_end) begin
          word_d[bitn_q] = line;
          if (bitn_q == BIT_LAST) begin
            bitn_d = '0;
`ifdef EXAMPLE_SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitn_d = bitn_q + 1'b1;
          end
        end
      end
`ifdef EXAMPLE_SERIAL_RX_PARITY_EN
      PARITY: begin
        if (cyc_end) begin
          par_d   = line;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cyc_end) begin
          if (line) begin
            good_stop = 1'b1;
            state_d   = IDLE;
          end else begin
            framing_err_d = 1'b1;
            state_d       = BREAK;
          end
        end
      end
      BREAK: begin
        cyc_d = '0;
        if (line) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    // A consumer draining the buffer this cycle frees room for the new word.
    if (good_stop) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = word_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
`ifdef EXAMPLE_SERIAL_RX_PARITY_EN
      parity_err_d = ^{word_q, par_q};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      cyc_q         <= '0;
      bitn_q        <= '0;
      word_q        <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef EXAMPLE_SERIAL_RX_PARITY_EN
      par_q         <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cyc_q         <= cyc_d;
      bitn_q        <= bitn_d;
      word_q        <= word_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
`ifdef EXAMPLE_SERIAL_RX_PARITY_EN
      par_q         <= par_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
`ifdef EXAMPLE_SERIAL_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
